// File: rtl/link_pkg.sv
`default_nettype none
// ============================================================================
// Module   : link_pkg
// Brief    : Shared types and constants for the serial-link transfer arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package link_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } link_state_e;

    // Requester identity
    typedef enum logic {
        REQ_CPU  = 1'b0,
        REQ_HOST = 1'b1
    } link_req_e;

    // Byte returned when an external-clock transfer finds no partner
    localparam logic [7:0] RX_NO_PARTNER = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/link_timeout_ctr.sv
`default_nettype none
// ============================================================================
// Module   : link_timeout_ctr
// Brief    : Watchdog counter for external-clock transfers. Counts enabled
//            cycles; expired is high during the TIMEOUT_CYCLES-th one.
// Revision : 1.0 - initial release
// ============================================================================
module link_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 2097152
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Expiry fires on the last enabled cycle so the owner can act on that edge
    always_comb begin
        expired = en && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
        cnt_d   = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expired) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/link_xfer_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : link_xfer_arbiter
// Brief    : Round-robin scheduler sharing the serial-link shifter between the
//            CPU (SB/SC) and a host channel. Owns grant, start, completion
//            routing and cancel. Optional external-clock watchdog is built
//            when LINK_TIMEOUT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module link_xfer_arbiter
    import link_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2097152,
    parameter int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cpu_req,
    input  logic       cpu_cancel,
    input  logic       cpu_int_clk,
    input  logic [7:0] cpu_tx,
    output logic       cpu_busy,
    output logic       cpu_done,
    output logic [7:0] cpu_rx,
    input  logic       host_req,
    input  logic       host_int_clk,
    input  logic [7:0] host_tx,
    output logic       host_ack,
    output logic [7:0] host_rx,
    output logic       xfer_start,
    output logic       xfer_int_clk,
    output logic [7:0] xfer_tx,
    output logic       xfer_abort,
    input  logic       xfer_done,
    input  logic [7:0] xfer_rx
);

    link_state_e state_q, state_d;
    link_req_e   winner_q, winner_d;
    link_req_e   last_grant_q, last_grant_d;

    logic       cpu_pend_q, cpu_pend_d;
    logic       cpu_int_clk_q, cpu_int_clk_d;
    logic [7:0] cpu_tx_q, cpu_tx_d;
    logic [7:0] cpu_rx_q, cpu_rx_d;
    logic [7:0] host_rx_q, host_rx_d;
    logic [7:0] xfer_tx_q, xfer_tx_d;
    logic       xfer_int_clk_q, xfer_int_clk_d;
    logic       xfer_abort_q, xfer_abort_d;

    logic       w_cpu_owned;
    logic       w_cpu_kill;
    logic       w_cpu_want;
    logic       w_pick_cpu;
    logic       w_timeout;

    // CPU currently holds the shifter (granted and not yet back in IDLE)
    assign w_cpu_owned = (state_q != IDLE) && (winner_q == REQ_CPU);
    // Cancel of an in-flight CPU transfer; DONE is already past the point of no return
    assign w_cpu_kill  = cpu_cancel && w_cpu_owned &&
                         ((state_q == GRANT) || (state_q == BUSY));
    // A same-cycle request is visible to arbitration so IDLE grants on the next edge
    assign w_cpu_want  = !w_cpu_owned && (cpu_req || (cpu_pend_q && !cpu_cancel));
    // Tie goes to whoever did not win last time
    assign w_pick_cpu  = w_cpu_want && (!host_req || (last_grant_q == REQ_HOST));

`ifdef LINK_TIMEOUT_EN
    logic w_to_clr;
    logic w_to_en;

    assign w_to_clr = (state_q == GRANT);
    assign w_to_en  = (state_q == BUSY) && !xfer_int_clk_q;

    link_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_to_clr),
        .en      (w_to_en),
        .expired (w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    // Width marker kept for the watchdog configuration; carries no logic
    logic [TO_W-1:0] w_unused_to_w;
    assign w_unused_to_w = '0;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            winner_q       <= REQ_CPU;
            last_grant_q   <= REQ_HOST;
            cpu_pend_q     <= 1'b0;
            cpu_int_clk_q  <= 1'b0;
            cpu_tx_q       <= 8'h00;
            cpu_rx_q       <= 8'h00;
            host_rx_q      <= 8'h00;
            xfer_tx_q      <= 8'h00;
            xfer_int_clk_q <= 1'b0;
            xfer_abort_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            winner_q       <= winner_d;
            last_grant_q   <= last_grant_d;
            cpu_pend_q     <= cpu_pend_d;
            cpu_int_clk_q  <= cpu_int_clk_d;
            cpu_tx_q       <= cpu_tx_d;
            cpu_rx_q       <= cpu_rx_d;
            host_rx_q      <= host_rx_d;
            xfer_tx_q      <= xfer_tx_d;
            xfer_int_clk_q <= xfer_int_clk_d;
            xfer_abort_q   <= xfer_abort_d;
        end
    end

    // Next-state logic: arbitration, completion, cancel and watchdog
    always_comb begin
        state_d      = state_q;
        winner_d     = winner_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            IDLE: begin
                if (w_cpu_want || host_req) begin
                    winner_d = w_pick_cpu ? REQ_CPU : REQ_HOST;
                    state_d  = GRANT;
                end
            end
            GRANT: begin
                last_grant_d = winner_q;
                state_d      = w_cpu_kill ? IDLE : BUSY;
            end
            BUSY: begin
                if (w_cpu_kill) begin
                    state_d = IDLE;
                end else if (xfer_done || w_timeout) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath: CPU request latch, shifter operand capture, rx routing, abort
    always_comb begin
        cpu_pend_d     = cpu_pend_q;
        cpu_int_clk_d  = cpu_int_clk_q;
        cpu_tx_d       = cpu_tx_q;
        cpu_rx_d       = cpu_rx_q;
        host_rx_d      = host_rx_q;
        xfer_tx_d      = xfer_tx_q;
        xfer_int_clk_d = xfer_int_clk_q;
        xfer_abort_d   = 1'b0;

        if (!w_cpu_owned) begin
            if (cpu_req) begin
                cpu_pend_d    = 1'b1;
                cpu_int_clk_d = cpu_int_clk;
                cpu_tx_d      = cpu_tx;
            end else if (cpu_cancel) begin
                cpu_pend_d = 1'b0;
            end
        end else if (w_cpu_kill || (state_q == DONE)) begin
            cpu_pend_d = 1'b0;
        end

        if (w_cpu_kill) begin
            xfer_abort_d = 1'b1;
        end

        // Operands are captured once so the shifter sees them stable for the whole transfer
        if ((state_q == IDLE) && (w_cpu_want || host_req)) begin
            if (w_pick_cpu) begin
                xfer_tx_d      = cpu_req ? cpu_tx      : cpu_tx_q;
                xfer_int_clk_d = cpu_req ? cpu_int_clk : cpu_int_clk_q;
            end else begin
                xfer_tx_d      = host_tx;
                xfer_int_clk_d = host_int_clk;
            end
        end

        if ((state_q == BUSY) && !w_cpu_kill) begin
            if (xfer_done) begin
                if (winner_q == REQ_CPU) cpu_rx_d  = xfer_rx;
                else                     host_rx_d = xfer_rx;
            end else if (w_timeout) begin
                xfer_abort_d = 1'b1;
                if (winner_q == REQ_CPU) cpu_rx_d  = RX_NO_PARTNER;
                else                     host_rx_d = RX_NO_PARTNER;
            end
        end
    end

    // Outputs: pulses decoded from state, levels straight from registers
    always_comb begin
        xfer_start   = (state_q == GRANT);
        cpu_done     = (state_q == DONE) && (winner_q == REQ_CPU);
        host_ack     = (state_q == DONE) && (winner_q == REQ_HOST);
        cpu_busy     = cpu_pend_q;
        cpu_rx       = cpu_rx_q;
        host_rx      = host_rx_q;
        xfer_tx      = xfer_tx_q;
        xfer_int_clk = xfer_int_clk_q;
        xfer_abort   = xfer_abort_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_link_xfer_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_link_xfer_arbiter
// Brief    : Scoreboard bench for link_xfer_arbiter. Stimulus pushes expected
//            shifter/completion events with their cycle; a monitor pops and
//            compares whenever the DUT pulses one. LINK_TIMEOUT_EN selects
//            the watchdog expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_link_xfer_arbiter;

    localparam int EV_ABORT = 0;
    localparam int EV_START = 1;
    localparam int EV_CPU   = 2;
    localparam int EV_HOST  = 3;

    typedef struct {
        int         kind;
        logic [7:0] data;
        logic       ic;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cpu_req = 1'b0, cpu_cancel = 1'b0, cpu_int_clk = 1'b0;
    logic [7:0] cpu_tx = 8'h00;
    logic       cpu_busy, cpu_done;
    logic [7:0] cpu_rx;
    logic       host_req = 1'b0, host_int_clk = 1'b0;
    logic [7:0] host_tx = 8'h00;
    logic       host_ack;
    logic [7:0] host_rx;
    logic       xfer_start, xfer_int_clk, xfer_abort;
    logic [7:0] xfer_tx;
    logic       xfer_done = 1'b0;
    logic [7:0] xfer_rx = 8'h00;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fails = 0;
    int   n_host_acks = 0;
    int   host_acks_seen = 0;

    logic       shf_en = 1'b1;
    int         shf_delay = 100;
    logic [7:0] shf_mask = 8'h00;

    link_xfer_arbiter #(.TIMEOUT_CYCLES(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_req      (cpu_req),
        .cpu_cancel   (cpu_cancel),
        .cpu_int_clk  (cpu_int_clk),
        .cpu_tx       (cpu_tx),
        .cpu_busy     (cpu_busy),
        .cpu_done     (cpu_done),
        .cpu_rx       (cpu_rx),
        .host_req     (host_req),
        .host_int_clk (host_int_clk),
        .host_tx      (host_tx),
        .host_ack     (host_ack),
        .host_rx      (host_rx),
        .xfer_start   (xfer_start),
        .xfer_int_clk (xfer_int_clk),
        .xfer_tx      (xfer_tx),
        .xfer_abort   (xfer_abort),
        .xfer_done    (xfer_done),
        .xfer_rx      (xfer_rx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string evname(input int k);
        case (k)
            EV_ABORT: return "abort";
            EV_START: return "start";
            EV_CPU:   return "cpu_done";
            default:  return "host_ack";
        endcase
    endfunction

    function automatic void push(input int kind, input logic [7:0] data, input logic ic, input int c);
        exp_t e;
        e.kind = kind; e.data = data; e.ic = ic; e.cyc = c;
        q.push_back(e);
    endfunction

    function automatic void sb_check(input int kind, input logic [7:0] data, input logic ic);
        exp_t e;
        n_checks++;
        if (q.size() == 0) begin
            n_fails++;
            $display("FAIL sb_unexpected: got %0s data=%02h clk=%0b at cyc %0d, required no event",
                     evname(kind), data, ic, cyc);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || e.data !== data || e.ic !== ic || e.cyc != cyc) begin
                n_fails++;
                $display("FAIL sb_%0s: got %0s data=%02h clk=%0b cyc=%0d, required %0s data=%02h clk=%0b cyc=%0d",
                         evname(e.kind), evname(kind), data, ic, cyc, evname(e.kind), e.data, e.ic, e.cyc);
            end
        end
    endfunction

    // Monitor: compare every DUT event against the scoreboard head
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (xfer_abort) sb_check(EV_ABORT, 8'h00, 1'b0);
            if (xfer_start) sb_check(EV_START, xfer_tx, xfer_int_clk);
            if (cpu_done)   sb_check(EV_CPU, cpu_rx, 1'b0);
            if (host_ack) begin
                sb_check(EV_HOST, host_rx, 1'b0);
                n_host_acks++;
            end
        end
    end

    // Shifter model: answers xfer_tx ^ shf_mask, read at completion time
    initial forever begin
        @(negedge clk);
        if (xfer_start && shf_en) begin
            repeat (shf_delay) @(posedge clk);
            #1;
            xfer_done = 1'b1;
            xfer_rx   = xfer_tx ^ shf_mask;
            @(posedge clk);
            #1;
            xfer_done = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (n_host_acks != host_acks_seen) begin
            host_acks_seen = n_host_acks;
            host_req = 1'b0;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %0s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic cpu_issue(input logic [7:0] tx, input logic ic);
        cpu_req = 1'b1; cpu_tx = tx; cpu_int_clk = ic;
        tick();
        cpu_req = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        for (int i = 0; i < budget && q.size() != 0; i++) tick();
        check({name, "_drain"}, q.size(), 0);
    endtask

    initial begin
        int n;
        int m;

        // Reset state
        do_reset();
        check("reset_ctl", {26'd0, cpu_busy, cpu_done, host_ack, xfer_start, xfer_abort, xfer_int_clk}, 0);
        check("reset_data", {8'h00, cpu_rx, host_rx, xfer_tx}, 0);

        // Basic internal-clock CPU transfer
        shf_delay = 100; shf_mask = 8'h99;
        n = cyc;
        push(EV_START, 8'hA5, 1'b1, n + 1);
        push(EV_CPU, 8'h3C, 1'b0, n + 102);
        cpu_issue(8'hA5, 1'b1);
        check("t1_busy_set", cpu_busy, 1);
        wait_drain("t1", 200);
        check("t1_busy_clear", cpu_busy, 0);
        check("t1_cpu_rx", cpu_rx, 8'h3C);

        // Tie after reset: CPU first, held host second
        do_reset();
        shf_delay = 10; shf_mask = 8'hFF;
        n = cyc;
        push(EV_START, 8'h11, 1'b1, n + 1);
        push(EV_CPU, 8'hEE, 1'b0, n + 12);
        push(EV_START, 8'h22, 1'b1, n + 14);
        push(EV_HOST, 8'hDD, 1'b0, n + 25);
        host_req = 1'b1; host_tx = 8'h22; host_int_clk = 1'b1;
        cpu_issue(8'h11, 1'b1);
        wait_drain("t2", 100);
        check("t2_host_rx", host_rx, 8'hDD);

        // Lone CPU transfer, then tie: host now wins
        shf_delay = 5;
        n = cyc;
        push(EV_START, 8'h33, 1'b1, n + 1);
        push(EV_CPU, 8'hCC, 1'b0, n + 7);
        cpu_issue(8'h33, 1'b1);
        wait_drain("t2b_lone", 50);
        m = cyc;
        push(EV_START, 8'h55, 1'b1, m + 1);
        push(EV_HOST, 8'hAA, 1'b0, m + 7);
        push(EV_START, 8'h44, 1'b1, m + 9);
        push(EV_CPU, 8'hBB, 1'b0, m + 15);
        host_req = 1'b1; host_tx = 8'h55; host_int_clk = 1'b1;
        cpu_issue(8'h44, 1'b1);
        wait_drain("t2b_tie", 100);

        // CPU request while host is in flight waits for host_ack
        shf_delay = 20; shf_mask = 8'h0F;
        n = cyc;
        push(EV_START, 8'h66, 1'b1, n + 1);
        push(EV_HOST, 8'h69, 1'b0, n + 22);
        push(EV_START, 8'h77, 1'b0, n + 24);
        push(EV_CPU, 8'h78, 1'b0, n + 45);
        host_req = 1'b1; host_tx = 8'h66; host_int_clk = 1'b1;
        tick();
        while (cyc < n + 5) tick();
        cpu_issue(8'h77, 1'b0);
        check("t3_busy_during_host", cpu_busy, 1);
        wait_drain("t3", 100);

        // Cancel of an in-flight external-clock CPU transfer
        shf_en = 1'b0; shf_mask = 8'h00; shf_delay = 3;
        n = cyc;
        push(EV_START, 8'h88, 1'b0, n + 1);
        push(EV_ABORT, 8'h00, 1'b0, n + 11);
        cpu_issue(8'h88, 1'b0);
        while (cyc < n + 10) tick();
        cpu_cancel = 1'b1;
        tick();
        cpu_cancel = 1'b0;
        check("t4_busy_after_cancel", cpu_busy, 0);
        shf_en = 1'b1;
        m = cyc;
        push(EV_START, 8'h9A, 1'b0, m + 1);
        push(EV_HOST, 8'h9A, 1'b0, m + 5);
        host_req = 1'b1; host_tx = 8'h9A; host_int_clk = 1'b0;
        wait_drain("t4", 50);

        // Cancel of a pending, not yet granted, CPU request
        shf_delay = 10;
        n = cyc;
        push(EV_START, 8'h10, 1'b1, n + 1);
        push(EV_HOST, 8'h10, 1'b0, n + 12);
        host_req = 1'b1; host_tx = 8'h10; host_int_clk = 1'b1;
        tick();
        while (cyc < n + 3) tick();
        cpu_issue(8'h20, 1'b1);
        check("t5_pend_set", cpu_busy, 1);
        tick();
        cpu_cancel = 1'b1;
        tick();
        cpu_cancel = 1'b0;
        check("t5_pend_cleared", cpu_busy, 0);
        wait_drain("t5", 50);
        repeat (5) tick();
        check("t5_no_cpu_xfer", cpu_busy, 0);

        // External clock, no partner
        shf_en = 1'b0;
        n = cyc;
`ifdef LINK_TIMEOUT_EN
        push(EV_START, 8'hC3, 1'b0, n + 1);
        push(EV_ABORT, 8'h00, 1'b0, n + 66);
        push(EV_CPU, 8'hFF, 1'b0, n + 66);
        cpu_issue(8'hC3, 1'b0);
        wait_drain("t6_timeout", 200);
        check("t6_rx_no_partner", cpu_rx, 8'hFF);
        check("t6_busy_clear", cpu_busy, 0);
`else
        push(EV_START, 8'hC3, 1'b0, n + 1);
        cpu_issue(8'hC3, 1'b0);
        repeat (1000) tick();
        check("t6_still_busy", cpu_busy, 1);
        check("t6_no_start_left", q.size(), 0);
        m = cyc;
        push(EV_ABORT, 8'h00, 1'b0, m + 1);
        cpu_cancel = 1'b1;
        tick();
        cpu_cancel = 1'b0;
        wait_drain("t6_cancel", 20);
        check("t6_busy_clear", cpu_busy, 0);
`endif
        shf_en = 1'b1;

        // Reset mid-transfer, then a late xfer_done must be ignored
        shf_delay = 30; shf_mask = 8'h00;
        n = cyc;
        push(EV_START, 8'hD2, 1'b1, n + 1);
        cpu_issue(8'hD2, 1'b1);
        while (cyc < n + 10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t7_rst_ctl", {26'd0, cpu_busy, cpu_done, host_ack, xfer_start, xfer_abort, xfer_int_clk}, 0);
        check("t7_rst_data", {8'h00, cpu_rx, host_rx, xfer_tx}, 0);
        while (cyc < n + 40) tick();
        check("t7_late_done_ignored", {30'd0, cpu_busy, cpu_rx == 8'h00}, 1);
        check("t7_scoreboard_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL global_timeout: got no end of stimulus, required completion within 200000 time units");
        $fatal(1, "global timeout");
    end

endmodule
`default_nettype wire
